// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - writeback select encoding, condition codes and nzp helper
package writeback_pkg;

   // Result select carried on W_Control
   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_PC  = 2'd1,
      WSEL_MEM = 2'd2,
      WSEL_NPC = 2'd3
   } wsel_e;

   // One-hot condition codes {N,Z,P}
   localparam logic [2:0] PSR_N = 3'b100;
   localparam logic [2:0] PSR_Z = 3'b010;
   localparam logic [2:0] PSR_P = 3'b001;

   // Condition code of a value given its sign bit and an all-zero flag
   function automatic logic [2:0] nzp(input logic msb, input logic is_zero);
      if (msb)
         return PSR_N;
      else if (is_zero)
         return PSR_Z;
      else
         return PSR_P;
   endfunction

endpackage

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file with one write port, NUM_RD async read ports and optional bypass
module wb_regfile #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   localparam int REG_AW  = $clog2(NUM_REGS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_we,
   input  logic [REG_AW-1:0]        i_waddr,
   input  logic [DATA_W-1:0]        i_wdata,
   input  logic [NUM_RD*REG_AW-1:0] i_raddr,
   output logic [NUM_RD*DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];

   // Clear every register on reset; otherwise write the selected entry when enabled
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Each read port is a plain array lookup; a same-cycle write to the same index
   // is forwarded only when bypass is built in and reset is not holding the array
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [REG_AW-1:0] w_ra;
      logic              w_hit;
      assign w_ra  = i_raddr[k*REG_AW +: REG_AW];
      assign w_hit = (BYPASS != 0) && i_we && !reset && (w_ra == i_waddr);
      assign o_rdata[k*DATA_W +: DATA_W] = w_hit ? i_wdata : r_mem[w_ra];
   end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback result mux, register file, condition codes and writeback counter
module writeback_unit
   import writeback_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   localparam int REG_AW  = $clog2(NUM_REGS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable_writeback,
   input  logic [1:0]               W_Control,
   input  logic [DATA_W-1:0]        aluout,
   input  logic [DATA_W-1:0]        pcout,
   input  logic [DATA_W-1:0]        memout,
   input  logic [DATA_W-1:0]        npc,
   input  logic [REG_AW-1:0]        dr,
   input  logic [NUM_RD*REG_AW-1:0] sr,
   output logic [NUM_RD*DATA_W-1:0] VSR,
   output logic [2:0]               psr,
   output logic                     wb_done,
   output logic [15:0]              wb_count
);

   logic [DATA_W-1:0] w_wb_value;
   logic [2:0]        r_psr;
   logic              r_wb_done;
   logic [15:0]       r_wb_count;

   // Select the value being written back this cycle
   always_comb begin
      w_wb_value = aluout;
      case (wsel_e'(W_Control))
         WSEL_ALU: w_wb_value = aluout;
         WSEL_PC:  w_wb_value = pcout;
         WSEL_MEM: w_wb_value = memout;
         WSEL_NPC: w_wb_value = npc;
         default:  w_wb_value = aluout;
      endcase
   end

   wb_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .i_we    (enable_writeback),
      .i_waddr (dr),
      .i_wdata (w_wb_value),
      .i_raddr (sr),
      .o_rdata (VSR)
   );

   // Condition codes, done pulse and counter move only on an accepted writeback
   always_ff @(posedge clock) begin
      if (reset) begin
         r_psr      <= 3'b000;
         r_wb_done  <= 1'b0;
         r_wb_count <= 16'h0000;
      end else begin
         r_wb_done <= enable_writeback;
         if (enable_writeback) begin
            r_psr      <= nzp(w_wb_value[DATA_W-1], w_wb_value == '0);
            r_wb_count <= r_wb_count + 16'd1;
         end
      end
   end

   assign psr      = r_psr;
   assign wb_done  = r_wb_done;
   assign wb_count = r_wb_count;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_writeback;
   logic [1:0]  W_Control;
   logic [15:0] aluout, pcout, memout, npc;
   logic [2:0]  dr;
   logic [5:0]  sr;
   logic [31:0] vsr_a, vsr_b;
   logic [2:0]  psr_a, psr_b;
   logic        done_a, done_b;
   logic [15:0] cnt_a, cnt_b;

   logic        w_en;
   logic [1:0]  w_ctl;
   logic [31:0] w_alu, w_pc, w_mem, w_npc;
   logic [3:0]  w_dr;
   logic [15:0] w_sr;
   logic [127:0] w_vsr;
   logic [2:0]  w_psr;
   logic        w_done;
   logic [15:0] w_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   writeback_unit #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1)) dut_a (
      .clock(clock), .reset(reset), .enable_writeback(enable_writeback), .W_Control(W_Control),
      .aluout(aluout), .pcout(pcout), .memout(memout), .npc(npc), .dr(dr), .sr(sr),
      .VSR(vsr_a), .psr(psr_a), .wb_done(done_a), .wb_count(cnt_a));

   writeback_unit #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(0)) dut_b (
      .clock(clock), .reset(reset), .enable_writeback(enable_writeback), .W_Control(W_Control),
      .aluout(aluout), .pcout(pcout), .memout(memout), .npc(npc), .dr(dr), .sr(sr),
      .VSR(vsr_b), .psr(psr_b), .wb_done(done_b), .wb_count(cnt_b));

   writeback_unit #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1)) dut_w (
      .clock(clock), .reset(reset), .enable_writeback(w_en), .W_Control(w_ctl),
      .aluout(w_alu), .pcout(w_pc), .memout(w_mem), .npc(w_npc), .dr(w_dr), .sr(w_sr),
      .VSR(w_vsr), .psr(w_psr), .wb_done(w_done), .wb_count(w_cnt));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable_writeback = 1'b0; W_Control = 2'd0;
      aluout = '0; pcout = '0; memout = '0; npc = '0; dr = '0; sr = '0;
      w_en = 1'b0; w_ctl = 2'd0; w_alu = '0; w_pc = '0; w_mem = '0; w_npc = '0;
      w_dr = '0; w_sr = '0;
      step(); step();
      check("rst_psr", psr_a, 3'b000);
      check("rst_done", done_a, 1'b0);
      check("rst_cnt", cnt_a, 16'h0);
      check("rst_vsr", vsr_a, 32'h0);

      // First writeback in the first cycle out of reset
      reset = 1'b0; enable_writeback = 1'b1; W_Control = 2'd0;
      aluout = 16'h8001; dr = 3'd3; sr = {3'd0, 3'd3};
      #1;
      check("byp_same_cycle", vsr_a[15:0], 16'h8001);
      check("nobyp_same_cycle", vsr_b[15:0], 16'h0000);
      step();
      enable_writeback = 1'b0;
      #1;
      check("r3_read", vsr_a[15:0], 16'h8001);
      check("r3_read_nobyp", vsr_b[15:0], 16'h8001);
      check("psr_n", psr_a, 3'b100);
      check("cnt_1", cnt_a, 16'd1);
      check("done_pulse", done_a, 1'b1);
      step();
      check("done_drop", done_a, 1'b0);

      // Preload R5, then overwrite with zero from memout; both ports read R5
      enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h0042; dr = 3'd5;
      step();
      check("psr_p", psr_a, 3'b001);
      W_Control = 2'd2; memout = 16'h0000; sr = {3'd5, 3'd5};
      #1;
      check("byp_port1", vsr_a[31:16], 16'h0000);
      check("byp_ports_equal", vsr_a[15:0], vsr_a[31:16]);
      check("nobyp_port1_old", vsr_b[31:16], 16'h0042);
      step();
      enable_writeback = 1'b0;
      #1;
      check("psr_z", psr_a, 3'b010);
      check("nobyp_port1_new", vsr_b[31:16], 16'h0000);
      check("cnt_3", cnt_a, 16'd3);

      // Reset collides with a writeback: discarded, and no bypass while in reset
      reset = 1'b1; enable_writeback = 1'b1; W_Control = 2'd3; npc = 16'h3000;
      dr = 3'd2; sr = {3'd3, 3'd2};
      #1;
      check("rst_no_bypass", vsr_a[15:0], 16'h0000);
      check("rst_shows_reg", vsr_a[31:16], 16'h8001);
      step();
      check("rst_r2", vsr_a[15:0], 16'h0000);
      check("rst_r3", vsr_a[31:16], 16'h0000);
      check("rst_wb_psr", psr_a, 3'b000);
      check("rst_wb_cnt", cnt_a, 16'h0);
      check("rst_wb_done", done_a, 1'b0);

      // Four back-to-back writebacks starting the first cycle after reset
      reset = 1'b0; W_Control = 2'd1;
      for (int i = 0; i < 4; i++) begin
         pcout = 16'(i + 1); dr = 3'(i);
         step();
         check($sformatf("b2b_done_%0d", i), done_a, 1'b1);
      end
      enable_writeback = 1'b0;
      step();
      check("b2b_done_end", done_a, 1'b0);
      for (int i = 0; i < 4; i++) begin
         sr = {3'(i), 3'(i)};
         #1;
         check($sformatf("b2b_r%0d", i), vsr_a[15:0], 32'(i + 1));
      end
      check("b2b_psr", psr_a, 3'b001);
      check("b2b_cnt", cnt_a, 16'd4);

      // Unknown select and destination with writeback disabled change nothing
      W_Control = 2'bxx; dr = 3'bxxx; sr = {3'd1, 3'd0};
      step();
      check("x_cnt", cnt_a, 16'd4);
      check("x_psr", psr_a, 3'b001);
      check("x_r0", vsr_a[15:0], 16'd1);

      // Drive the counter to 16'hFFFF, then one more wraps it
      enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h0005; dr = 3'd7;
      for (int i = 0; i < 65531; i++) begin
         @(posedge clock);
      end
      #1;
      check("cnt_ffff", cnt_a, 16'hFFFF);
      aluout = 16'h8000;
      step();
      enable_writeback = 1'b0;
      #1;
      check("cnt_wrap", cnt_a, 16'h0000);
      check("wrap_psr", psr_a, 3'b100);
      check("wrap_done", done_a, 1'b1);

      // Wide configuration: reset, single write, sign from bit 31, back-to-back
      reset = 1'b1;
      step();
      reset = 1'b0; w_en = 1'b1; w_ctl = 2'd0; w_alu = 32'h8000_0001; w_dr = 4'd3;
      w_sr = {4'd0, 4'd0, 4'd0, 4'd3};
      step();
      w_en = 1'b0;
      #1;
      check("w_r3", w_vsr[31:0], 32'h8000_0001);
      check("w_psr_n", w_psr, 3'b100);
      check("w_cnt_1", w_cnt, 16'd1);
      w_en = 1'b1; w_alu = 32'h0000_8000; w_dr = 4'd4;
      step();
      check("w_psr_bit15", w_psr, 3'b001);
      w_ctl = 2'd1;
      for (int i = 0; i < 4; i++) begin
         w_pc = 32'(i + 1); w_dr = 4'(i);
         step();
         check($sformatf("w_done_%0d", i), w_done, 1'b1);
      end
      w_en = 1'b0; w_sr = {4'd3, 4'd2, 4'd1, 4'd0};
      #1;
      check("w_r0_r3", w_vsr, {32'd4, 32'd3, 32'd2, 32'd1});
      check("w_psr_p", w_psr, 3'b001);
      check("w_cnt_6", w_cnt, 16'd6);
      step();
      check("w_done_end", w_done, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
